// File: rtl/cordic_fix2float.sv
// Converts the signed fixed-point cosine result of the CORDIC core into an IEEE-754 single.
// The normaliser shifts one bit per cycle and the result is rounded to nearest-even.
module cordic_fix2float #(
  parameter int FRAC_BITS = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cordic_busy,
  input  logic [31:0] fix_in,
  input  logic        negate,
  output logic [31:0] float_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun
);

  localparam int EXP_BASE = 127 + 31 - FRAC_BITS;

  typedef enum logic [2:0] {IDLE, ABS, NORM, ROUND, OUT} state_t;

  state_t      state;
  state_t      state_next;
  logic        busy_q;
  logic        done;
  logic [31:0] fix_q;
  logic        neg_q;
  logic        sign_q;
  logic [31:0] mag_q;
  logic [4:0]  k_q;
  logic [31:0] float_q;
  logic        overrun_q;

  logic [31:0] abs_val;
  logic [22:0] mant_trunc;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [23:0] mant_sum;
  logic [7:0]  exp_biased;

  assign done    = busy_q & ~cordic_busy;
  // 0x80000000 negates to itself, which is exactly the unsigned magnitude we want.
  assign abs_val = fix_q[31] ? (~fix_q + 32'd1) : fix_q;

  // Round-to-nearest-even; a carry out of the mantissa bumps the exponent.
  assign mant_trunc = mag_q[30:8];
  assign guard      = mag_q[7];
  assign sticky     = |mag_q[6:0];
  assign round_up   = guard & (sticky | mant_trunc[0]);
  assign mant_sum   = {1'b0, mant_trunc} + {23'd0, round_up};
  assign exp_biased = 8'(EXP_BASE) - {3'd0, k_q} + {7'd0, mant_sum[23]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (done) state_next = ABS;
      ABS:     state_next = (abs_val == 32'd0) ? OUT : NORM;
      NORM:    if (mag_q[31]) state_next = ROUND;
      ROUND:   state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == OUT);
    float_out = float_q;
    overrun   = overrun_q;
  end

  // Datapath; samples are only captured in IDLE, anything arriving later is flagged and dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q    <= 1'b0;
      fix_q     <= 32'd0;
      neg_q     <= 1'b0;
      sign_q    <= 1'b0;
      mag_q     <= 32'd0;
      k_q       <= 5'd0;
      float_q   <= 32'd0;
      overrun_q <= 1'b0;
    end else begin
      busy_q <= cordic_busy;
      if (done && state != IDLE) begin
        overrun_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (done) begin
            fix_q <= fix_in;
            neg_q <= negate;
          end
        end
        ABS: begin
          sign_q <= fix_q[31] ^ neg_q;
          mag_q  <= abs_val;
          k_q    <= 5'd0;
          if (abs_val == 32'd0) begin
            float_q <= 32'd0;
          end
        end
        NORM: begin
          if (!mag_q[31]) begin
            mag_q <= mag_q << 1;
            k_q   <= k_q + 5'd1;
          end
        end
        ROUND: begin
          float_q <= {sign_q, exp_biased, mant_sum[22:0]};
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_fix2float.sv
// Self-checking bench for cordic_fix2float: directed vector table, random vectors against
// an arithmetic float model, and hand-written backpressure, overrun and reset sequences.
module tb_cordic_fix2float;

  localparam int FRAC_BITS = 30;

  logic        clk = 1'b0;
  logic        reset;
  logic        cordic_busy;
  logic [31:0] fix_in;
  logic        negate;
  logic [31:0] float_out;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic [31:0] fix;
    logic        neg;
    logic [31:0] expFloat;
    int          expLat;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  cordic_fix2float #(.FRAC_BITS(FRAC_BITS)) dut (
    .clk(clk),
    .reset(reset),
    .cordic_busy(cordic_busy),
    .fix_in(fix_in),
    .negate(negate),
    .float_out(float_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun(overrun)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Reference: locate the leading one, then round the discarded bits by comparing to half an ulp.
  function automatic void refModel(input logic [31:0] fix, input logic neg,
                                   output logic [31:0] f, output int lat);
    longint mag, q, rem, half;
    int p, e, sh;
    logic s;
    s   = fix[31] ^ neg;
    mag = fix[31] ? (64'h1_0000_0000 - longint'(fix)) : longint'(fix);
    if (mag == 0) begin
      f   = 32'd0;
      lat = 2;
      return;
    end
    p = 0;
    for (int i = 31; i >= 0; i--) begin
      if (mag[i]) begin
        p = i;
        break;
      end
    end
    e = p - FRAC_BITS + 127;
    if (p >= 23) begin
      sh  = p - 23;
      q   = mag >> sh;
      rem = mag - (q << sh);
      if (sh > 0) begin
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
      end
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
    end else begin
      q = mag << (23 - p);
    end
    f   = {s, 8'(e), q[22:0]};
    lat = 4 + 31 - p;
  endfunction

  task automatic pulseBusy(input logic [31:0] fix, input logic neg);
    @(negedge clk);
    fix_in      = fix;
    negate      = neg;
    cordic_busy = 1'b1;
    @(negedge clk);
    cordic_busy = 1'b0;
  endtask

  // Waits for out_valid after a completion edge; returns -1 if it never appears.
  task automatic waitValid(output int lat);
    lat = -1;
    for (int j = 1; j <= 80; j++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = j;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input logic [31:0] fix, input logic neg, input logic [31:0] expFloat,
                               input int expLat, input string tag);
    int lat;
    out_ready = 1'b1;
    pulseBusy(fix, neg);
    waitValid(lat);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_float"}, float_out, expFloat);
    @(negedge clk);
    checkOutput({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] rf, ef;
    logic        rn;
    int          el, lat;
    bit          sawValid;

    reset       = 1'b0;
    cordic_busy = 1'b0;
    fix_in      = 32'd0;
    negate      = 1'b0;
    out_ready   = 1'b0;

    vecs[0] = '{32'h4000_0000, 1'b0, 32'h3F80_0000, 5};
    vecs[1] = '{32'h26DD_3B6A, 1'b0, 32'h3F1B_74EE, 6};
    vecs[2] = '{32'hE000_0000, 1'b0, 32'hBF00_0000, 6};
    vecs[3] = '{32'h4000_0000, 1'b1, 32'hBF80_0000, 5};
    vecs[4] = '{32'h8000_0000, 1'b0, 32'hC000_0000, 4};
    vecs[5] = '{32'h7FFF_FFC0, 1'b0, 32'h4000_0000, 5};
    vecs[6] = '{32'h4000_0040, 1'b0, 32'h3F80_0000, 5};
    vecs[7] = '{32'h0000_0000, 1'b1, 32'h0000_0000, 2};
    vecs[8] = '{32'h0000_0001, 1'b0, 32'h3080_0000, 35};
    vecs[9] = '{32'hFFFF_FFFF, 1'b1, 32'h3080_0000, 35};

    repeat (2) @(negedge clk);
    checkOutput("reset_float", float_out, 32'd0);
    checkOutput("reset_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_overrun", {31'd0, overrun}, 32'd0);
    reset = 1'b1;
    sawValid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid === 1'b1) sawValid = 1'b1;
    end
    checkOutput("post_reset_no_spurious", {31'd0, sawValid}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].fix, vecs[i].neg, vecs[i].expFloat, vecs[i].expLat, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      rf = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) rf = 32'd0;
      if ($urandom_range(0, 1) == 1) rf = ~rf;
      rn = 1'($urandom_range(0, 1));
      refModel(rf, rn, ef, el);
      applyStimulus(rf, rn, ef, el, $sformatf("rand%0d", i));
    end
    checkOutput("no_overrun_yet", {31'd0, overrun}, 32'd0);

    // Backpressure with a second completion arriving while the first result waits.
    out_ready = 1'b0;
    pulseBusy(32'h4000_0000, 1'b0);
    waitValid(lat);
    checkOutput("bp_latency", 32'(lat), 32'd5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 2) begin
        fix_in      = 32'hE000_0000;
        cordic_busy = 1'b1;
      end
      if (i == 3) cordic_busy = 1'b0;
      checkOutput($sformatf("bp_hold_valid%0d", i), {31'd0, out_valid}, 32'd1);
      checkOutput($sformatf("bp_hold_float%0d", i), float_out, 32'h3F80_0000);
    end
    checkOutput("bp_overrun", {31'd0, overrun}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_transfer_drop", {31'd0, out_valid}, 32'd0);
    sawValid = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid === 1'b1) sawValid = 1'b1;
    end
    checkOutput("bp_second_dropped", {31'd0, sawValid}, 32'd0);
    checkOutput("bp_overrun_sticky", {31'd0, overrun}, 32'd1);

    // Reset in the middle of a long normalisation.
    pulseBusy(32'h0000_0001, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_norm_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_norm_float", float_out, 32'd0);
    checkOutput("rst_norm_overrun", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    sawValid = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (out_valid === 1'b1) sawValid = 1'b1;
    end
    checkOutput("rst_norm_nothing_emitted", {31'd0, sawValid}, 32'd0);

    // Reset while a result is being presented clears out_valid without a clock edge.
    out_ready = 1'b0;
    pulseBusy(32'h4000_0000, 1'b1);
    waitValid(lat);
    checkOutput("rst_out_latency", 32'(lat), 32'd5);
    checkOutput("rst_out_float", float_out, 32'hBF80_0000);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rst_out_valid_async", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    applyStimulus(vecs[1].fix, vecs[1].neg, vecs[1].expFloat, vecs[1].expLat, "recover");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
